// File: rtl/hamming_rx_decoder.sv
// Serial Hamming(7,4) receiver: frames the incoming bit stream, corrects
// single-bit errors and holds the recovered nibble in a one-entry buffer.
module hamming_rx_decoder #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               sof,
  output logic [3:0]         data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               err_corrected,
  output logic [COUNT_W-1:0] corr_count,
  output logic               overrun,
  output logic               sync_err
);

  localparam int unsigned CW_W  = 7;
  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CW_W-1:0]    c_q, c_d;
  logic [3:0]         data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               err_corr_q, err_corr_d;
  logic [COUNT_W-1:0] corr_count_q, corr_count_d;
  logic               overrun_q, overrun_d;
  logic               sync_err_q, sync_err_d;

  logic [CW_W-1:0]    w;
  logic [CW_W-1:0]    flip;
  logic [CW_W-1:0]    w_fix;
  logic [2:0]         syn;
  logic [3:0]         nib;
  logic               word_done;

  // Syndrome decode of the word formed by the current shift contents plus bit_in
  always_comb begin
    w      = {c_q[5:0], bit_in};
    syn[0] = w[6] ^ w[4] ^ w[2] ^ w[0];
    syn[1] = w[5] ^ w[4] ^ w[1] ^ w[0];
    syn[2] = w[3] ^ w[2] ^ w[1] ^ w[0];
    flip   = '0;
    // Hamming position p lives at w[7-p]
    if (syn != 3'd0) begin
      flip = 7'b100_0000 >> (syn - 3'd1);
    end
    w_fix  = w ^ flip;
    nib    = {w_fix[4], w_fix[2], w_fix[1], w_fix[0]};
  end

  // Framing, output buffer and status next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    c_d          = c_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    err_corr_d   = err_corr_q;
    corr_count_d = corr_count_q;
    overrun_d    = overrun_q;
    sync_err_d   = sync_err_q;
    word_done    = 1'b0;

    if (bit_valid) begin
      if (sof) begin
        // sof mid-word (including the 7th position) abandons the partial word
        if ((state_q == RECV) && (cnt_q != 3'd0)) begin
          sync_err_d = 1'b1;
        end
        state_d = RECV;
        cnt_d   = 3'd1;
        c_d     = {6'b0, bit_in};
      end else if (state_q == RECV) begin
        c_d = {c_q[5:0], bit_in};
        if (cnt_q == 3'd6) begin
          cnt_d     = 3'd0;
          word_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
    end

    if (word_done) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = nib;
        err_corr_d   = (syn != 3'd0);
        data_valid_d = 1'b1;
        if ((syn != 3'd0) && (corr_count_q != {COUNT_W{1'b1}})) begin
          corr_count_d = corr_count_q + COUNT_W'(1);
        end
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      c_q          <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      err_corr_q   <= 1'b0;
      corr_count_q <= '0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      c_q          <= c_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      err_corr_q   <= err_corr_d;
      corr_count_q <= corr_count_d;
      overrun_q    <= overrun_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign err_corrected = err_corr_q;
  assign corr_count    = corr_count_q;
  assign overrun       = overrun_q;
  assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_hamming_rx_decoder.sv
// Bench for hamming_rx_decoder: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a behavioural Hamming model.
module tb_hamming_rx_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        sof;
  logic        data_ready;
  logic [3:0]  data_out, data_out2;
  logic        data_valid, data_valid2;
  logic        err_c, err_c2;
  logic [15:0] corr_count;
  logic [1:0]  corr_count2;
  logic        overrun, overrun2;
  logic        sync_err, sync_err2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic       m_valid;
  logic [3:0] m_data;
  logic       m_err;
  int         m_cnt, m_cnt2;
  logic       m_ovr, m_sync;
  int         rdy_mode;   // 0: always ready, 1: random, 2: never ready
  logic       mid;        // a partial word is outstanding
  logic       framed;     // a frame has been started since reset

  always #5 clk = ~clk;

  hamming_rx_decoder #(.COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .err_corrected(err_c), .corr_count(corr_count), .overrun(overrun),
    .sync_err(sync_err)
  );

  hamming_rx_decoder #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .data_out(data_out2), .data_valid(data_valid2), .data_ready(data_ready),
    .err_corrected(err_c2), .corr_count(corr_count2), .overrun(overrun2),
    .sync_err(sync_err2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Codeword in wire order (p1 first) for a nibble {x3,x2,x1,x0}
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [7:1] p;
    p    = '0;
    p[3] = d[3]; p[5] = d[2]; p[6] = d[1]; p[7] = d[0];
    p[1] = p[3] ^ p[5] ^ p[7];
    p[2] = p[3] ^ p[6] ^ p[7];
    p[4] = p[5] ^ p[6] ^ p[7];
    return {p[1], p[2], p[3], p[4], p[5], p[6], p[7]};
  endfunction

  // Syndrome = XOR of the positions holding a 1; flip that position
  task automatic ref_decode(input logic [6:0] cw, output logic [3:0] d, output logic e);
    logic [7:1] p;
    int syn;
    syn = 0;
    for (int i = 1; i <= 7; i++) begin
      p[i] = cw[7-i];
      if (p[i]) syn = syn ^ i;
    end
    if (syn != 0) p[syn] = ~p[syn];
    d = {p[3], p[5], p[6], p[7]};
    e = (syn != 0);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it
  task automatic tick(input logic r, input logic bv, input logic b, input logic s,
                      input logic last, input logic [6:0] cw, input logic sync_set);
    logic       rdy;
    logic [3:0] d;
    logic       e;
    if (rdy_mode == 0)      rdy = 1'b1;
    else if (rdy_mode == 2) rdy = 1'b0;
    else                    rdy = 1'($urandom_range(0, 1));
    rst = r; bit_valid = bv; bit_in = b; sof = s; data_ready = rdy;
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_err = 1'b0; m_cnt = 0; m_cnt2 = 0;
      m_ovr = 1'b0; m_sync = 1'b0; mid = 1'b0; framed = 1'b0;
    end else begin
      if (sync_set) m_sync = 1'b1;
      if (last) begin
        ref_decode(cw, d, e);
        if (!m_valid || rdy) begin
          m_valid = 1'b1; m_data = d; m_err = e;
          if (e) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
          end
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_eq("data_valid", 32'(data_valid), 32'(m_valid));
    check_eq("data_out", 32'(data_out), 32'(m_data));
    check_eq("err_corrected", 32'(err_c), 32'(m_err));
    check_eq("corr_count", 32'(corr_count), 32'(m_cnt));
    check_eq("corr_count_w2", 32'(corr_count2), 32'(m_cnt2));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    check_eq("sync_err", 32'(sync_err), 32'(m_sync));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 7'd0, 1'b0);
    end
  endtask

  task automatic do_reset();
    tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 7'd0, 1'b0);
  endtask

  task automatic send_word(input logic [6:0] cw, input logic with_sof, input int max_gap);
    logic s;
    for (int i = 0; i < 7; i++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      s = (i == 0) && with_sof;
      tick(1'b0, 1'b1, cw[6-i], s, 1'(i == 6), cw, s && mid);
      if (s) begin
        mid    = 1'b0;
        framed = 1'b1;
      end
    end
  endtask

  // sof plus n-1 further bits, leaving the word unfinished
  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b1, 1'($urandom), 1'(i == 0), 1'b0, 7'd0, (i == 0) && mid);
    end
    mid    = 1'b1;
    framed = 1'b1;
  endtask

  function automatic logic [6:0] corrupt(input logic [6:0] cw, input int nflips);
    logic [6:0] r;
    logic [6:0] one;
    r   = cw;
    one = 7'd1;
    for (int i = 0; i < nflips; i++) r = r ^ (one << $urandom_range(0, 6));
    return r;
  endfunction

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0; data_ready = 1'b1;
    m_valid = 1'b0; m_data = '0; m_err = 1'b0; m_cnt = 0; m_cnt2 = 0;
    m_ovr = 1'b0; m_sync = 1'b0; mid = 1'b0; framed = 1'b0;
    rdy_mode = 0;

    // Reset state
    do_reset();
    do_reset();

    // Clean word, then single-bit errors in a data bit and in p1
    send_word(encode(4'b1011), 1'b1, 0);
    idle(2);
    send_word(7'b0110111, 1'b1, 0);
    idle(1);
    send_word(7'b1110011, 1'b1, 0);
    idle(1);

    // Back-to-back words after a single sof
    send_word(encode(4'b0000), 1'b1, 0);
    send_word(encode(4'b1111), 1'b0, 0);
    send_word(encode(4'b1011), 1'b0, 0);
    idle(2);

    // Backpressure: second word dropped, first held, then popped
    rdy_mode = 2;
    send_word(encode(4'b0101), 1'b1, 0);
    send_word(encode(4'b1100), 1'b0, 0);
    idle(3);
    rdy_mode = 0;
    idle(2);

    // Framing error, including sof landing on the 7th bit position
    do_reset();
    send_partial(3);
    send_word(encode(4'b0110), 1'b1, 0);
    idle(2);
    send_partial(6);
    send_word(encode(4'b0011), 1'b1, 0);
    idle(1);

    // Reset mid-word, unframed bits ignored, next word decodes normally
    send_partial(4);
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0, 7'd0, 1'b0);
    send_word(encode(4'b1001), 1'b1, 0);
    idle(2);

    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) begin
      send_word(corrupt(encode(4'($urandom)), 1) ^ 7'b000_0000, 1'b1, 0);
      send_word(encode(4'($urandom)) ^ (7'd1 << (i + 1)), 1'b1, 1);
    end
    idle(2);

    // Randomized traffic
    do_reset();
    rdy_mode = 1;
    for (int it = 0; it < 300; it++) begin
      int pick;
      pick = $urandom_range(0, 99);
      if (pick < 3) begin
        do_reset();
      end else if (pick < 10) begin
        send_partial($urandom_range(1, 6));
      end else if (pick < 15) begin
        idle($urandom_range(1, 8));
      end else begin
        int nf;
        logic ws;
        nf = $urandom_range(0, 3);
        nf = (nf >= 2) ? nf - 1 : 0;
        ws = (mid || !framed) ? 1'b1 : 1'($urandom_range(0, 1));
        send_word(corrupt(encode(4'($urandom)), nf), ws, $urandom_range(0, 2));
      end
    end
    rdy_mode = 0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_rx_decoder.md
# hamming_rx_decoder

Serial receive-side stage that consumes the 7-bit Hamming(7,4) codewords produced by the transmit encoder after they have crossed the channel one bit per cycle. It frames the bit stream, computes the 3-bit syndrome, corrects any single-bit error and presents the recovered 4-bit nibble on a valid/ready output with a one-entry holding register. Status outputs report per-word correction, a saturating correction count, overrun and framing errors.

## Interface
- COUNT_W, 16, width of the saturating correction counter
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- bit_in  in  1  serial codeword bit
- bit_valid  in  1  bit_in is valid this cycle
- sof  in  1  start of frame; qualified by bit_valid, marks the first bit of a codeword
- data_out  out  4  corrected nibble {x3,x2,x1,x0}
- data_valid  out  1  data_out holds an unconsumed word
- data_ready  in  1  downstream accepts data_out when data_valid && data_ready
- err_corrected  out  1  nonzero syndrome for the word in data_out; same timing as data_out
- corr_count  out  COUNT_W  number of accepted-into-buffer words with nonzero syndrome, saturates at all-ones
- overrun  out  1  sticky: a completed word was dropped because the buffer was full
- sync_err  out  1  sticky: sof arrived mid-word

## Operation
- Codeword bit order on the wire, first to last: p1, p2, x3, p4, x2, x1, x0 (Hamming positions 1..7). Shift register c[6:0] is filled MSB-first, so c[6]=p1 and c[0]=x0.
- States: IDLE, RECV.
  - IDLE: bits are ignored until bit_valid && sof; that bit is stored as bit 1 and the state goes to RECV with bit count 1.
  - RECV: each bit_valid shifts in bit_in and increments the count. On the 7th bit the word completes, the count returns to 0 and the state stays RECV, so back-to-back codewords need no sof.
  - bit_valid && sof while in RECV with count 1..6 discards the partial word, sets sync_err and restarts with this bit as bit 1. sof with count 0 is a normal start and sets no flag.
  - bit_valid low: hold all state, with no timeout.
- Decode runs combinationally on the completed word w = {c[5:0], bit_in}:
  - s1 = w6^w4^w2^w0, s2 = w5^w4^w1^w0, s4 = w3^w2^w1^w0.
  - syn = {s4,s2,s1}. If syn is nonzero, invert w[7-syn]. Data is {w4,w2,w1,w0} after correction.
  - Parity-bit errors (syn 1, 2 or 4) still assert err_corrected; the data is unchanged.
  - Double errors are miscorrected silently. This is SEC only, with no detection of double errors.
- Output buffer, on a word-complete cycle:
  - If the buffer is empty, or data_valid && data_ready in the same cycle, load data_out and err_corrected, set data_valid, and increment corr_count if syn is nonzero.
  - Otherwise drop the word, set overrun, and leave the buffer and corr_count unchanged.
- data_valid && data_ready with no new word clears data_valid.
- Sticky flags clear only on rst.

## Timing
- rst reset values: state IDLE, count 0, c 0, data_out 0, data_valid 0, err_corrected 0, corr_count 0, overrun 0, sync_err 0.
- rst has priority over all inputs in the same cycle. Reset mid-word discards the partial word and any buffered word.
- Latency: the 7th bit is sampled at edge N, and data_valid and data_out are valid after edge N, i.e. one cycle.
- Maximum throughput is one word per 7 cycles. With data_ready held high, no overrun can occur.
- data_out and err_corrected are stable while data_valid && !data_ready.
- corr_count holds at 2^COUNT_W-1 once reached.
- Simultaneous events:
  - Pop and load in the same cycle: the buffer is replaced and data_valid stays 1.
  - sof on the 7th bit position (count 6): sof wins. The partial word is discarded, sync_err is set and no word completes.

## Test plan
- Clean word: sof then 0,1,1,0,0,1,1 (data 1011), data_ready=1 -> data_out=4'b1011, err_corrected=0, data_valid high exactly one cycle, corr_count=0.
- Data-bit error: 0,1,1,0,1,1,1 (position 5 flipped) -> data_out=4'b1011, err_corrected=1, corr_count=1. Repeat with p1 flipped (1,1,1,0,0,1,1) -> data 1011, err_corrected=1, corr_count=2.
- Back-to-back: three codewords for 0000, 1111, 1011 in 21 consecutive valid bits with a single sof -> three outputs in order, 7 cycles apart, no flags.
- Backpressure: data_ready=0 across two full words -> first word held stable, second dropped, overrun=1. Then data_ready=1 -> first word popped, data_valid=0.
- Framing: sof, 3 bits, then sof plus a full clean word for 0110 -> sync_err=1, single output 0110.
- Reset and saturation: rst asserted at bit 4 -> all outputs 0 and the next word decodes normally. With COUNT_W=2 and 5 erroneous words -> corr_count=3.
